// File: rtl/iterative_multiply_unit.sv
// iterative_multiply_unit
//   Multi-cycle WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier. One adder
//   does all the work: it negates the operands (signed mode), forms the
//   partial-product sums, and negates the product in two halves.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request, sampled when busy=0 (IDLE or DONE)
//   isSigned  two's-complement operands when 1, sampled with start
//   a, b      multiplicand / multiplier, bit 0 = MSB, sampled with start
//   busy      operation in progress
//   done      one-cycle result-valid pulse
//   prodHi    upper product half, bit 0 = MSB, held until the next result
//   prodLo    lower product half, bit 0 = MSB, held until the next result

module adder_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module iterative_multiply_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isSigned,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] prodHi,
  output logic [0:WIDTH-1] prodLo
);

  // state | meaning
  // IDLE  | waiting for start
  // NEGA  | M <= -M (magnitude of negative multiplicand)
  // NEGB  | Q <= -Q (magnitude of negative multiplier)
  // RUN   | WIDTH shift-and-add steps
  // NEGLO | negate low half, keep carry in k
  // NEGHI | negate high half using k
  // DONE  | result registered to outputs on the exit edge; may accept start

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_RUN, S_NEGLO, S_NEGHI, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Ports are MSB-at-bit-0; internally everything is [WIDTH-1:0] so that
  // bit 0 is the LSB. Vector assignment preserves the numeric value.
  logic [WIDTH-1:0] a_v, b_v;
  logic [WIDTH-1:0] m, q, p;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_cin, cout;
  logic             k, sgn_b_r, neg_r, done_r;
  logic             accept, sgn_a, sgn_b, last;
  logic [CW-1:0]    cnt;

  assign a_v    = a;
  assign b_v    = b;
  assign sgn_a  = isSigned & a_v[WIDTH-1];
  assign sgn_b  = isSigned & b_v[WIDTH-1];
  assign accept = start & ((state == S_IDLE) | (state == S_DONE));
  assign last   = (cnt == CW'(WIDTH - 1));

  adder_unit #(.W(WIDTH)) u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (sum),
    .cout(cout)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_NEGA: begin
        add_a   = ~m;
        add_cin = 1'b1;
      end
      S_NEGB, S_NEGLO: begin
        add_a   = ~q;
        add_cin = 1'b1;
      end
      S_RUN: begin
        add_a = p;
        add_b = q[0] ? m : '0;
      end
      S_NEGHI: begin
        add_a   = ~p;
        add_cin = k;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (sgn_a)      state_nxt = S_NEGA;
          else if (sgn_b) state_nxt = S_NEGB;
          else            state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_NEGA:  state_nxt = sgn_b_r ? S_NEGB : S_RUN;
      S_NEGB:  state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = neg_r ? S_NEGLO : S_DONE;
      S_NEGLO: state_nxt = S_NEGHI;
      S_NEGHI: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      S_NEGA, S_NEGB, S_RUN, S_NEGLO, S_NEGHI: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      q       <= '0;
      p       <= '0;
      k       <= 1'b0;
      cnt     <= '0;
      sgn_b_r <= 1'b0;
      neg_r   <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      // done and the product registers update on the edge leaving DONE
      done_r <= (state == S_DONE);
      if (state == S_DONE) begin
        hi_r <= p;
        lo_r <= q;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            m       <= a_v;
            q       <= b_v;
            p       <= '0;
            k       <= 1'b0;
            cnt     <= '0;
            sgn_b_r <= sgn_b;
            neg_r   <= sgn_a ^ sgn_b;
          end
        end
        S_NEGA: m <= sum;
        S_NEGB: q <= sum;
        S_RUN: begin
          // {P,Q} <= {c, s, Q} >> 1: the adder carry becomes the new P MSB
          p   <= {cout, sum[WIDTH-1:1]};
          q   <= {sum[0], q[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        S_NEGLO: begin
          q <= sum;
          k <= cout;
        end
        S_NEGHI: p <= sum;
        default: ;
      endcase
    end
  end

  assign done   = done_r;
  assign prodHi = hi_r;
  assign prodLo = lo_r;

endmodule

// File: tb/tb_iterative_multiply_unit.sv
module tb_iterative_multiply_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn_i;
  logic [31:0] a_i, b_i;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  iterative_multiply_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .isSigned(sgn_i),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .prodHi  (hi),
    .prodLo  (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_prod(input logic [31:0] av, input logic [31:0] bv,
                                             input bit sv);
    logic [63:0] xa, xb;
    xa = sv ? {{32{av[31]}}, av} : {32'b0, av};
    xb = sv ? {{32{bv[31]}}, bv} : {32'b0, bv};
    return xa * xb;
  endfunction

  function automatic int model_lat(input logic [31:0] av, input logic [31:0] bv, input bit sv);
    int sa, sb;
    sa = (sv && av[31]) ? 1 : 0;
    sb = (sv && bv[31]) ? 1 : 0;
    return 1 + 32 + sa + sb + 2 * (sa ^ sb);
  endfunction

  task automatic push_exp(input logic [31:0] av, input logic [31:0] bv, input bit sv);
    exp_t e;
    e.prod = model_prod(av, bv, sv);
    e.lat  = model_lat(av, bv, sv);
    exp_q.push_back(e);
  endtask

  // Drives one operation and reports what the DUT did; no comparisons here.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit sv,
                        output logic [63:0] prod, output int lat, output int bcnt,
                        output bit hold_ok);
    logic [63:0] prev;
    prev = {hi, lo};
    @(negedge clk);
    a_i = av; b_i = bv; sgn_i = sv; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = -1;
    bcnt    = (busy === 1'b1) ? 1 : 0;
    hold_ok = ({hi, lo} === prev);
    for (int e = 1; e <= 120 && lat < 0; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = e;
      else begin
        if (busy === 1'b1) bcnt++;
        if ({hi, lo} !== prev) hold_ok = 1'b0;
      end
    end
    prod = {hi, lo};
  endtask

  task automatic test_reset;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++;
    if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_prod got=%h want=0", {hi, lo}); end
  endtask

  task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb[],
                           input bit sv);
    logic [63:0] prod;
    int lat, bcnt;
    bit hold_ok;
    exp_t e;
    for (int i = 0; i < ta.size(); i++) begin
      push_exp(ta[i], tb[i], sv);
      run_op(ta[i], tb[i], sv, prod, lat, bcnt, hold_ok);
      e = exp_q.pop_front();
      total++;
      if (prod !== e.prod) begin
        bad++; $display("FAIL %s_prod[%0d] got=%h want=%h", name, i, prod, e.prod);
      end
      total++;
      if (lat !== e.lat) begin
        bad++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, i, lat, e.lat);
      end
      total++;
      if (bcnt !== e.lat - 1) begin
        bad++; $display("FAIL %s_busy_cycles[%0d] got=%0d want=%0d", name, i, bcnt, e.lat - 1);
      end
      total++;
      if (hold_ok !== 1'b1) begin
        bad++; $display("FAIL %s_hold[%0d] got=%b want=1", name, i, hold_ok);
      end
    end
  endtask

  task automatic test_unsigned;
    logic [31:0] ta[] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h0001_0000, 32'h0};
    logic [31:0] tb[] = '{32'd6, 32'hFFFF_FFFF, 32'd12345, 32'h0001_0000, 32'h0};
    ta[4] = $urandom;
    tb[4] = $urandom;
    run_table("unsigned", ta, tb, 1'b0);
  endtask

  task automatic test_signed;
    logic [31:0] ta[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7,         32'h8000_0000};
    logic [31:0] tb[] = '{32'd5,         32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 32'd1};
    run_table("signed", ta, tb, 1'b1);
  endtask

  task automatic test_busy_ignore;
    logic [63:0] prod;
    int lat;
    exp_t e;
    push_exp(32'h1234, 32'h5678, 1'b0);
    @(negedge clk);
    a_i = 32'h1234; b_i = 32'h5678; sgn_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int e2 = 1; e2 <= 120 && lat < 0; e2++) begin
      if (e2 == 10) begin
        @(negedge clk);
        a_i = 32'hFFFF; b_i = 32'hFFFF; sgn_i = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      if (e2 == 10) start = 1'b0;
      if (done === 1'b1) lat = e2;
    end
    prod = {hi, lo};
    e = exp_q.pop_front();
    total++;
    if (prod !== e.prod) begin bad++; $display("FAIL ignore_prod got=%h want=%h", prod, e.prod); end
    total++;
    if (lat !== e.lat) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, e.lat); end
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL ignore_after got busy,done=%b want=00", {busy, done});
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    exp_t e1, e2;
    push_exp(32'd100, 32'd200, 1'b0);
    push_exp(32'hFFFF_FFF0, 32'd3, 1'b1);
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd200; sgn_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // start stays high: ignored while busy, accepted in DONE
    a_i = 32'hFFFF_FFF0; b_i = 32'd3; sgn_i = 1'b1;
    lat1 = -1;
    for (int e = 1; e <= 120 && lat1 < 0; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat1 = e;
    end
    start = 1'b0;
    e1 = exp_q.pop_front();
    total++;
    if ({hi, lo} !== e1.prod) begin
      bad++; $display("FAIL b2b_first_prod got=%h want=%h", {hi, lo}, e1.prod);
    end
    total++;
    if (lat1 !== e1.lat) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat1, e1.lat); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
    lat2 = -1;
    for (int e = 1; e <= 120 && lat2 < 0; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat2 = e;
    end
    e2 = exp_q.pop_front();
    total++;
    if ({hi, lo} !== e2.prod) begin
      bad++; $display("FAIL b2b_second_prod got=%h want=%h", {hi, lo}, e2.prod);
    end
    total++;
    if (lat2 !== e2.lat) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat2, e2.lat); end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] prod;
    int lat, bcnt;
    bit hold_ok, seen;
    exp_t e;
    @(negedge clk);
    a_i = 32'd9; b_i = 32'd9; sgn_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++;
    if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL midrst_prod got=%h want=0", {hi, lo}); end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", seen); end
    push_exp(32'hDEAD_BEEF, 32'h10, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h10, 1'b0, prod, lat, bcnt, hold_ok);
    e = exp_q.pop_front();
    total++;
    if (prod !== e.prod) begin bad++; $display("FAIL midrst_fresh_prod got=%h want=%h", prod, e.prod); end
    total++;
    if (lat !== e.lat) begin bad++; $display("FAIL midrst_fresh_latency got=%0d want=%0d", lat, e.lat); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sgn_i = 1'b0; a_i = '0; b_i = '0;
    #2 rst = 1'b1;
    #10;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_unsigned;
    test_signed;
    test_busy_ignore;
    test_back_to_back;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
